// File: rtl/sobel_dir_pkg.sv
// Shared Sobel definitions: direction codes and pixel field widths.
// The Sobel direction stage and the NMS stage both import this package.
package sobel_dir_pkg;

  localparam int MAG_WIDTH  = 11;
  localparam int DATA_WIDTH = MAG_WIDTH + 2;

  // Gradient direction, quantised to four orientations.
  typedef enum logic [1:0] {
    DIR_H   = 2'b00,  // compare left / right
    DIR_45  = 2'b01,  // compare top-right / bottom-left
    DIR_V   = 2'b10,  // compare top / bottom
    DIR_135 = 2'b11   // compare top-left / bottom-right
  } dir_e;

endpackage

// File: rtl/sobel_nms_3x3_if.sv
// Three-row input stream plus the single thinned-edge output stream.
// Row 0 is line y+1 (newest), row 1 is the centre line y, and row 2 is line y-1 (oldest).
interface sobel_nms_3x3_if #(
  parameter int DATA_WIDTH = sobel_dir_pkg::DATA_WIDTH
);
  logic                  s_axis_row0_tvalid;
  logic [DATA_WIDTH-1:0] s_axis_row0_tdata;
  logic                  s_axis_row0_tlast;
  logic                  s_axis_row0_tuser;
  logic                  s_axis_row1_tvalid;
  logic [DATA_WIDTH-1:0] s_axis_row1_tdata;
  logic                  s_axis_row1_tlast;
  logic                  s_axis_row1_tuser;
  logic                  s_axis_row2_tvalid;
  logic [DATA_WIDTH-1:0] s_axis_row2_tdata;
  logic                  s_axis_row2_tlast;
  logic                  s_axis_row2_tuser;
  logic                  m_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  // Stage view: consumes the row streams and drives the output stream.
  modport slave (
    input  s_axis_row0_tvalid, s_axis_row0_tdata, s_axis_row0_tlast, s_axis_row0_tuser,
    input  s_axis_row1_tvalid, s_axis_row1_tdata, s_axis_row1_tlast, s_axis_row1_tuser,
    input  s_axis_row2_tvalid, s_axis_row2_tdata, s_axis_row2_tlast, s_axis_row2_tuser,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
  );

  // Neighbour view: drives the row streams and consumes the output stream.
  modport master (
    output s_axis_row0_tvalid, s_axis_row0_tdata, s_axis_row0_tlast, s_axis_row0_tuser,
    output s_axis_row1_tvalid, s_axis_row1_tdata, s_axis_row1_tlast, s_axis_row1_tuser,
    output s_axis_row2_tvalid, s_axis_row2_tdata, s_axis_row2_tlast, s_axis_row2_tuser,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/nms_compare.sv
// Combinational non-maximum test for a single centre pixel against its 3x3 neighbourhood.
// The tie rule is asymmetric: the centre must be strictly greater than the first neighbour A,
// and greater than or equal to the second neighbour B. As a result, a 2-pixel plateau keeps exactly one pixel.
module nms_compare #(
  parameter int W = sobel_dir_pkg::MAG_WIDTH
) (
  input  logic [1:0]   i_dir,
  input  logic [W-1:0] i_c,
  input  logic [W-1:0] i_tl,
  input  logic [W-1:0] i_t,
  input  logic [W-1:0] i_tr,
  input  logic [W-1:0] i_l,
  input  logic [W-1:0] i_r,
  input  logic [W-1:0] i_bl,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_br,
  output logic [W-1:0] o_mag
);
  import sobel_dir_pkg::*;

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;

  // Pick the (A, B) neighbour pair that lies along the gradient direction.
  always_comb begin
    w_a = i_l;
    w_b = i_r;
    case (i_dir)
      DIR_H:   begin w_a = i_l;  w_b = i_r;  end
      DIR_45:  begin w_a = i_tr; w_b = i_bl; end
      DIR_V:   begin w_a = i_t;  w_b = i_b;  end
      DIR_135: begin w_a = i_tl; w_b = i_br; end
      default: begin w_a = i_l;  w_b = i_r;  end
    endcase
  end

  assign o_mag = ((i_c > w_a) && (i_c >= w_b)) ? i_c : '0;

endmodule

// File: rtl/sobel_nms_3x3.sv
// Non-maximum suppression over the three Sobel row streams.
// The window holds two registered columns (x-2, x-1). The incoming beat supplies column x.
// Accepting column x therefore decides column x-1, and the result is registered out the next cycle.
// Column W-1 is emitted as a flush beat on the cycle after the tlast column's own output.
module sobel_nms_3x3 #(
  parameter int DATA_WIDTH = sobel_dir_pkg::DATA_WIDTH,
  parameter int MAG_WIDTH  = sobel_dir_pkg::MAG_WIDTH,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_areset,
  sobel_nms_3x3_if.slave   bus
);

  localparam int ROW_W = 12;

  // r_mag[row][0] holds column x-2 and r_mag[row][1] holds column x-1. Row 0 is y+1 and row 2 is y-1.
  logic [2:0][1:0][MAG_WIDTH-1:0] r_mag;
  logic [1:0]                     r_cdir;       // direction of centre-row column x-1
  logic                           r_line_start; // next accept is column 0
  logic                           r_out_col0;   // next output is column 0 of the line
  logic                           r_sof;        // current line began with row1_tuser
  logic                           r_border;     // current centre row is a border row
  logic                           r_flush;      // emit column W-1 this cycle
  logic                           r_armed;      // a start of frame has been seen since reset
  logic [ROW_W-1:0]               r_row;

  logic                           r_o_valid;
  logic [DATA_WIDTH-1:0]          r_o_data;
  logic                           r_o_last;
  logic                           r_o_user;

  logic                           w_acc;
  logic                           w_col0;
  logic                           w_armed;
  logic [ROW_W-1:0]               w_row;
  logic [2:0][MAG_WIDTH-1:0]      w_new;
  logic [MAG_WIDTH-1:0]           w_cmp_mag;
  logic [MAG_WIDTH-1:0]           w_out_mag;
  logic                           w_unused;

  assign w_acc   = bus.s_axis_row1_tvalid;
  assign w_col0  = r_line_start | bus.s_axis_row1_tuser;
  assign w_armed = r_armed | bus.s_axis_row1_tuser;
  assign w_row   = bus.s_axis_row1_tuser ? '0 : r_row;

  // When the newest row is absent (last-row flush), it reads as zero.
  assign w_new[0] = bus.s_axis_row0_tvalid ? bus.s_axis_row0_tdata[MAG_WIDTH-1:0] : '0;
  assign w_new[1] = bus.s_axis_row1_tdata[MAG_WIDTH-1:0];
  assign w_new[2] = bus.s_axis_row2_tdata[MAG_WIDTH-1:0];

  nms_compare #(.W(MAG_WIDTH)) u_cmp (
    .i_dir (r_cdir),
    .i_c   (r_mag[1][1]),
    .i_tl  (r_mag[2][0]),
    .i_t   (r_mag[2][1]),
    .i_tr  (w_new[2]),
    .i_l   (r_mag[1][0]),
    .i_r   (w_new[1]),
    .i_bl  (r_mag[0][0]),
    .i_b   (r_mag[0][1]),
    .i_br  (w_new[0]),
    .o_mag (w_cmp_mag)
  );

  // Column 0 and border rows are forced to zero. The flush path handles column W-1.
  assign w_out_mag = (r_out_col0 || r_border) ? '0 : w_cmp_mag;

  // Window shift, line/frame control, row counter and output register.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_mag        <= '0;
      r_cdir       <= '0;
      r_line_start <= 1'b1;
      r_out_col0   <= 1'b0;
      r_sof        <= 1'b0;
      r_border     <= 1'b0;
      r_flush      <= 1'b0;
      r_armed      <= 1'b0;
      r_row        <= '0;
      r_o_valid    <= 1'b0;
      r_o_data     <= '0;
      r_o_last     <= 1'b0;
      r_o_user     <= 1'b0;
    end else begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_user  <= 1'b0;
      r_flush   <= 1'b0;
      // Column W-1 is always a border pixel, so only its direction is carried out.
      // An accept in this cycle can only be column 0, which produces no output.
      if (r_flush) begin
        r_o_valid <= 1'b1;
        r_o_data  <= DATA_WIDTH'({r_cdir, {MAG_WIDTH{1'b0}}});
        r_o_last  <= 1'b1;
      end else if (w_acc && !w_col0) begin
        r_o_valid <= r_armed;
        r_o_data  <= DATA_WIDTH'({r_cdir, w_out_mag});
        r_o_user  <= r_out_col0 & r_sof;
      end
      if (w_acc) begin
        for (int k = 0; k < 3; k++) begin
          r_mag[k][0] <= r_mag[k][1];
          r_mag[k][1] <= w_new[k];
        end
        r_cdir       <= bus.s_axis_row1_tdata[DATA_WIDTH-1 -: 2];
        r_out_col0   <= w_col0;
        r_line_start <= bus.s_axis_row1_tlast;
        r_flush      <= bus.s_axis_row1_tlast & w_armed;
        r_armed      <= w_armed;
        if (w_col0) begin
          r_sof    <= bus.s_axis_row1_tuser;
          r_border <= (w_row == '0) || (w_row == ROW_W'(IMG_HEIGHT - 1));
        end
        if (bus.s_axis_row1_tlast) r_row <= w_row + 1'b1;
        else                       r_row <= w_row;
      end
    end
  end

  assign bus.m_axis_tvalid = r_o_valid;
  assign bus.m_axis_tdata  = r_o_data;
  assign bus.m_axis_tlast  = r_o_last;
  assign bus.m_axis_tuser  = r_o_user;

  // Framing of the neighbour rows and their direction fields carry no information here.
  assign w_unused = ^{bus.s_axis_row0_tdata[DATA_WIDTH-1 -: 2], bus.s_axis_row2_tdata[DATA_WIDTH-1 -: 2],
                      bus.s_axis_row0_tlast, bus.s_axis_row0_tuser, bus.s_axis_row2_tvalid,
                      bus.s_axis_row2_tlast, bus.s_axis_row2_tuser};

endmodule

// File: tb/tb_sobel_nms_3x3.sv
// Bench for sobel_nms_3x3: frames of pixels are built in an image array.
// Each frame is streamed as the three Sobel rows and scored against a per-pixel NMS model.
module tb_sobel_nms_3x3;
  import sobel_dir_pkg::*;

  localparam int H    = 4;   // IMG_HEIGHT of the DUT: rows 0 and 3 are border rows
  localparam int MAXH = 8;
  localparam int MAXW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_nms_3x3_if bus ();

  sobel_nms_3x3 #(.IMG_HEIGHT(H)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .bus           (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  logic [12:0] img [MAXH][MAXW];
  int fh, fw;
  logic [14:0] exp_q[$];
  logic [14:0] obs_log[$];
  bit sb_en = 1'b1;
  int n_valid_seen = 0;

  // Reference model: neighbours outside the frame read as zero.
  function automatic logic [10:0] nb(input int y, input int x);
    if (y < 0 || y >= fh || x < 0 || x >= fw) return 11'd0;
    return img[y][x][10:0];
  endfunction

  function automatic logic [14:0] ref_beat(input int y, input int x);
    logic [1:0]  d;
    logic [10:0] m, a, b, o;
    d = img[y][x][12:11];
    m = img[y][x][10:0];
    case (d)
      2'b00:   begin a = nb(y, x-1);   b = nb(y, x+1);   end
      2'b01:   begin a = nb(y-1, x+1); b = nb(y+1, x-1); end
      2'b10:   begin a = nb(y-1, x);   b = nb(y+1, x);   end
      default: begin a = nb(y-1, x-1); b = nb(y+1, x+1); end
    endcase
    o = (m > a && m >= b) ? m : 11'd0;
    if (x == 0 || x == fw-1 || y == 0 || y == H-1) o = 11'd0;
    return {(y == 0 && x == 0), (x == fw-1), d, o};
  endfunction

  function automatic logic [12:0] rnd_pix();
    logic [1:0]  d;
    logic [10:0] m;
    d = 2'($urandom_range(0, 3));
    m = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 7));
    return {d, m};
  endfunction

  function automatic logic [14:0] get(input int i);
    if (i < obs_log.size()) return obs_log[i];
    return 15'h7fff;
  endfunction

  // Scoreboard: compare every output beat in order against the model queue.
  always @(negedge clk) begin
    if (bus.m_axis_tvalid === 1'b1) begin
      n_valid_seen++;
      if (sb_en) begin
        obs_log.push_back({bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata});
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else chk("beat", {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata}, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    bus.s_axis_row0_tvalid = 1'b0; bus.s_axis_row1_tvalid = 1'b0; bus.s_axis_row2_tvalid = 1'b0;
    bus.s_axis_row0_tlast  = 1'b0; bus.s_axis_row1_tlast  = 1'b0; bus.s_axis_row2_tlast  = 1'b0;
    bus.s_axis_row0_tuser  = 1'b0; bus.s_axis_row1_tuser  = 1'b0; bus.s_axis_row2_tuser  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One beat of the three row streams for centre pixel (y, x). sof=0 suppresses tuser.
  task automatic drive_beat(input int y, input int x, input bit sof);
    bus.s_axis_row1_tvalid = 1'b1;
    bus.s_axis_row1_tdata  = img[y][x];
    bus.s_axis_row1_tlast  = (x == fw-1);
    bus.s_axis_row1_tuser  = sof && (y == 0) && (x == 0);
    bus.s_axis_row0_tvalid = (y + 1 < fh);
    bus.s_axis_row0_tdata  = (y + 1 < fh) ? img[y+1][x] : 13'($urandom);
    bus.s_axis_row0_tlast  = bus.s_axis_row1_tlast;
    bus.s_axis_row0_tuser  = bus.s_axis_row1_tuser;
    bus.s_axis_row2_tvalid = 1'b1;
    bus.s_axis_row2_tdata  = (y > 0) ? img[y-1][x] : 13'd0;
    bus.s_axis_row2_tlast  = bus.s_axis_row1_tlast;
    bus.s_axis_row2_tuser  = bus.s_axis_row1_tuser;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bit gaps);
    for (int y = 0; y < fh; y++)
      for (int x = 0; x < fw; x++)
        exp_q.push_back(ref_beat(y, x));
    for (int y = 0; y < fh; y++)
      for (int x = 0; x < fw; x++) begin
        if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        drive_beat(y, x, 1'b1);
      end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    idle(4);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_img(input int h, input int w);
    fh = h; fw = w;
    for (int y = 0; y < MAXH; y++)
      for (int x = 0; x < MAXW; x++) img[y][x] = 13'd0;
    obs_log.delete();
  endtask

  int pk[5]  = '{0, 0, 9, 0, 0};
  int tie[4] = '{0, 7, 0, 0};
  int seen;

  initial begin
    idle(0);
    bus.s_axis_row0_tdata = '0; bus.s_axis_row1_tdata = '0; bus.s_axis_row2_tdata = '0;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_out", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A line before any start of frame must stay silent.
    clear_img(1, 4);
    for (int x = 0; x < 4; x++) img[0][x] = rnd_pix();
    for (int x = 0; x < 4; x++) drive_beat(0, x, 1'b0);
    idle(4);
    chk("unarmed_quiet", obs_log.size(), 0);

    // Isolated peak in centre row 1, DIR_H.
    clear_img(3, 5);
    for (int x = 0; x < 5; x++) img[1][x] = {2'b00, 11'(x == 2 ? 9 : (x == 1 || x == 3) ? 5 : 0)};
    send_frame(1'b0); drain();
    chk("peak_count", obs_log.size(), 15);
    for (int i = 0; i < 5; i++) chk($sformatf("peak_c%0d", i), get(5 + i) & 15'h07ff, pk[i]);
    chk("peak_tlast", get(9) >> 13, 2'b01);

    // Horizontal plateau: left pixel kept.
    clear_img(3, 4);
    img[1][1] = 13'd7; img[1][2] = 13'd7;
    send_frame(1'b0); drain();
    for (int i = 0; i < 4; i++) chk($sformatf("tieh_c%0d", i), get(4 + i) & 15'h07ff, tie[i]);

    // Vertical plateau in rows 1 and 2: top pixel kept.
    clear_img(4, 3);
    img[1][1] = {DIR_V, 11'd7}; img[2][1] = {DIR_V, 11'd7};
    send_frame(1'b0); drain();
    chk("tiev_top", get(4) & 15'h1fff, 13'h1007);
    chk("tiev_bot", get(7) & 15'h1fff, 13'h1000);

    // Diagonals.
    clear_img(3, 3);
    img[1][1] = {DIR_45, 11'd8}; img[0][2] = 13'd9;
    send_frame(1'b0); drain();
    chk("diag45", get(4) & 15'h1fff, 13'h0800);
    clear_img(3, 3);
    img[1][1] = {DIR_135, 11'd8}; img[0][0] = 13'd7; img[2][2] = 13'd8;
    send_frame(1'b0); drain();
    chk("diag135", get(4) & 15'h1fff, 13'h1808);

    // Framing: 4x4 frame with mags 10, back-to-back lines.
    clear_img(4, 4);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) img[y][x] = {2'($urandom_range(0, 3)), 11'd10};
    send_frame(1'b0); drain();
    chk("frm_count", obs_log.size(), 16);
    for (int i = 0; i < 16 && i < obs_log.size(); i++) begin
      chk($sformatf("frm_tuser%0d", i), obs_log[i][14], (i == 0));
      chk($sformatf("frm_tlast%0d", i), obs_log[i][13], (i % 4 == 3));
      if (i / 4 == 0 || i / 4 == 3) chk($sformatf("frm_border%0d", i), obs_log[i][10:0], 0);
    end

    // Reset mid-line 2: silence until the next start of frame, then an exact frame.
    sb_en = 1'b0;
    clear_img(8, 16);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) img[y][x] = rnd_pix();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 16; x++) drive_beat(y, x, 1'b1);
    for (int x = 0; x < 5; x++) drive_beat(2, x, 1'b1);
    rst = 1'b1;
    drive_beat(2, 5, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata}, 32'd0);
    @(posedge clk); #1;
    seen = n_valid_seen;
    for (int x = 6; x < 16; x++) drive_beat(2, x, 1'b1);
    for (int x = 0; x < 16; x++) drive_beat(3, x, 1'b1);
    idle(4);
    chk("rst_quiet", n_valid_seen - seen, 0);
    exp_q.delete();
    sb_en = 1'b1;
    clear_img(8, 16);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) img[y][x] = rnd_pix();
    send_frame(1'b0); drain();

    // Random 64x8 frames: two back to back, then two with gapped tvalid.
    for (int f = 0; f < 4; f++) begin
      clear_img(8, 64);
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 64; x++) img[y][x] = rnd_pix();
      send_frame(f >= 2);
      if (f == 1 || f == 3) drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
